mc10_kbd_matrix: RTL and testbench

MC10_KBD_MATRIX -- requirements
Module: mc10_kbd_matrix

---
 rtl/mc10_kbd_matrix.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mc10_kbd_matrix.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mc10_kbd_matrix.sv
// PS/2 to MC-10 keyboard matrix: decodes key events, holds keys for a minimum time, and synthesises SHIFT for remapped keys.
// Decode runs 1 cycle after toggle detect; while a sequence is in flight one event is buffered and further events are dropped (ovf).
module mc10_kbd_matrix #(
  parameter logic [15:0] SETTLE   = 16'd2000,
  parameter logic [19:0] HOLD_MIN = 20'd100000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  addr,
  output logic [5:0]  kb_rows,
  output logic        shift,
  output logic        ctrl,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, SYN_SHIFT, KEY_ON, HOLD, SYN_REL} state_t;

  typedef struct packed {
    logic       prs;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] row;
    logic [2:0] col;
    logic       fsh;
    logic       fun;
  } dec_t;

  // Position literals are octal {row, col}.
  function automatic dec_t decode(input logic [8:0] key);
    dec_t       d;
    logic [5:0] p;
    d     = '0;
    p     = 6'o00;
    d.vld = 1'b1;
    case (key)
      9'h054: p = 6'o00;
      9'h01C: p = 6'o01;
      9'h032: p = 6'o02;
      9'h021: p = 6'o03;
      9'h023: p = 6'o04;
      9'h024: p = 6'o05;
      9'h02B: p = 6'o06;
      9'h034: p = 6'o07;
      9'h033: p = 6'o10;
      9'h043: p = 6'o11;
      9'h03B: p = 6'o12;
      9'h042: p = 6'o13;
      9'h04B: p = 6'o14;
      9'h03A: p = 6'o15;
      9'h031: p = 6'o16;
      9'h044: p = 6'o17;
      9'h04D: p = 6'o20;
      9'h015: p = 6'o21;
      9'h02D: p = 6'o22;
      9'h01B: p = 6'o23;
      9'h02C: p = 6'o24;
      9'h03C: p = 6'o25;
      9'h02A: p = 6'o26;
      9'h01D: p = 6'o27;
      9'h022: p = 6'o30;
      9'h035: p = 6'o31;
      9'h01A: p = 6'o32;
      9'h175: p = 6'o33;
      9'h172: p = 6'o34;
      9'h16B: p = 6'o35;
      9'h174: p = 6'o36;
      9'h029: p = 6'o37;
      9'h045: p = 6'o40;
      9'h016: p = 6'o41;
      9'h01E: begin p = 6'o42; d.fun = 1'b1; end
      9'h026: p = 6'o43;
      9'h025: p = 6'o44;
      9'h02E: p = 6'o45;
      9'h036: p = 6'o46;
      9'h03D: p = 6'o47;
      9'h03E: p = 6'o50;
      9'h046: p = 6'o51;
      9'h05B: p = 6'o52;
      9'h04C: p = 6'o53;
      9'h041: p = 6'o54;
      9'h04E: p = 6'o55;
      9'h049: p = 6'o56;
      9'h04A: p = 6'o57;
      // Apostrophe is SHIFT+7 and '=' is SHIFT+'-' on the MC-10.
      9'h052: begin p = 6'o47; d.fsh = 1'b1; end
      9'h055: begin p = 6'o55; d.fsh = 1'b1; end
      default: d.vld = 1'b0;
    endcase
    d.row = p[5:3];
    d.col = p[2:0];
    return d;
  endfunction

  state_t          state, state_n;
  logic            tog_q, tog_init;
  logic            evt_vld;
  evt_t            evt;
  logic            pend_vld, pend_vld_n;
  evt_t            pend, pend_n;
  logic [19:0]     cnt, cnt_n;
  logic [5:0][7:0] mat, mat_n;
  logic            def_vld, def_vld_n;
  logic [5:0]      def_pos, def_pos_n;
  logic [5:0]      hold_pos, hold_pos_n;
  logic [8:0]      cur_key, cur_key_n;
  logic [5:0]      cur_pos, cur_pos_n;
  logic            ovr_act, ovr_act_n;
  logic            ovr_val, ovr_val_n;
  logic            ovf_q, ovf_n;
  logic            shl, shr, phys_ctrl;
  logic            evt_shl, evt_shr, evt_ctrl, evt_key;
  logic            evt_taken;
  evt_t            act;
  dec_t            dec;

  // Modifiers bypass the sequencer and the pending buffer.
  assign evt_shl  = evt_vld && !evt.ext && (evt.code == 8'h12);
  assign evt_shr  = evt_vld && !evt.ext && (evt.code == 8'h59);
  assign evt_ctrl = evt_vld && (evt.code == 8'h14);
  assign evt_key  = evt_vld && !evt_shl && !evt_shr && !evt_ctrl;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      tog_init <= 1'b0;
      evt_vld  <= 1'b0;
      evt      <= '0;
    end else begin
      tog_q    <= ps2_key[10];
      tog_init <= 1'b1;
      evt_vld  <= tog_init && (ps2_key[10] != tog_q);
      evt      <= ps2_key[9:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    mat_n      = mat;
    cnt_n      = (cnt != '0) ? cnt - 20'd1 : '0;
    def_vld_n  = def_vld;
    def_pos_n  = def_pos;
    hold_pos_n = hold_pos;
    cur_key_n  = cur_key;
    cur_pos_n  = cur_pos;
    ovr_act_n  = ovr_act;
    ovr_val_n  = ovr_val;
    pend_vld_n = pend_vld;
    pend_n     = pend;
    ovf_n      = ovf_q;
    evt_taken  = 1'b0;
    act        = pend_vld ? pend : evt;
    dec        = decode({act.ext, act.code});

    if (def_vld && cnt == '0) begin
      mat_n[def_pos[5:3]][def_pos[2:0]] = 1'b0;
      def_vld_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (pend_vld || evt_key) begin
          if (pend_vld) pend_vld_n = 1'b0;
          else          evt_taken  = 1'b1;
          if (dec.vld && act.prs) begin
            if (def_vld_n) begin
              mat_n[def_pos[5:3]][def_pos[2:0]] = 1'b0;
              def_vld_n = 1'b0;
            end
            if (!mat_n[dec.row][dec.col]) begin
              if (dec.fsh || dec.fun) begin
                ovr_act_n = 1'b1;
                ovr_val_n = dec.fsh;
                cnt_n     = {4'd0, SETTLE};
                cur_key_n = {act.ext, act.code};
                cur_pos_n = {dec.row, dec.col};
                state_n   = SYN_SHIFT;
              end else begin
                mat_n[dec.row][dec.col] = 1'b1;
                cnt_n      = HOLD_MIN;
                hold_pos_n = {dec.row, dec.col};
              end
            end
          end else if (dec.vld && mat_n[dec.row][dec.col]) begin
            // The running counter belongs to the most recent plain press only.
            if (cnt != '0 && hold_pos == {dec.row, dec.col}) begin
              def_vld_n = 1'b1;
              def_pos_n = {dec.row, dec.col};
            end else begin
              mat_n[dec.row][dec.col] = 1'b0;
            end
          end
        end
      end
      SYN_SHIFT: begin
        if (cnt == '0) begin
          mat_n[cur_pos[5:3]][cur_pos[2:0]] = 1'b1;
          cnt_n   = HOLD_MIN;
          state_n = KEY_ON;
        end
      end
      KEY_ON: begin
        // A release buffered during SYN_SHIFT must also end the hold, or the sequence would stall.
        if (pend_vld && !pend.prs && {pend.ext, pend.code} == cur_key) begin
          pend_vld_n = 1'b0;
          state_n    = HOLD;
        end else if (evt_key && !evt.prs && {evt.ext, evt.code} == cur_key) begin
          evt_taken = 1'b1;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          mat_n[cur_pos[5:3]][cur_pos[2:0]] = 1'b0;
          cnt_n   = {4'd0, SETTLE};
          state_n = SYN_REL;
        end
      end
      SYN_REL: begin
        if (cnt == '0) begin
          ovr_act_n = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (evt_key && !evt_taken) begin
      if (pend_vld_n) begin
        ovf_n = 1'b1;
      end else begin
        pend_vld_n = 1'b1;
        pend_n     = evt;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mat       <= '0;
      cnt       <= '0;
      def_vld   <= 1'b0;
      def_pos   <= '0;
      hold_pos  <= '0;
      cur_key   <= '0;
      cur_pos   <= '0;
      ovr_act   <= 1'b0;
      ovr_val   <= 1'b0;
      pend_vld  <= 1'b0;
      pend      <= '0;
      ovf_q     <= 1'b0;
      shl       <= 1'b0;
      shr       <= 1'b0;
      phys_ctrl <= 1'b0;
    end else begin
      mat       <= mat_n;
      cnt       <= cnt_n;
      def_vld   <= def_vld_n;
      def_pos   <= def_pos_n;
      hold_pos  <= hold_pos_n;
      cur_key   <= cur_key_n;
      cur_pos   <= cur_pos_n;
      ovr_act   <= ovr_act_n;
      ovr_val   <= ovr_val_n;
      pend_vld  <= pend_vld_n;
      pend      <= pend_n;
      ovf_q     <= ovf_n;
      if (evt_shl)  shl       <= evt.prs;
      if (evt_shr)  shr       <= evt.prs;
      if (evt_ctrl) phys_ctrl <= evt.prs;
    end
  end

  always_comb begin
    kb_rows = '1;
    for (int r = 0; r < 6; r++) kb_rows[r] = ~|(mat[r] & ~addr);
  end

  assign shift = ovr_act ? ovr_val : (shl | shr);
  assign ctrl  = phys_ctrl;
  assign busy  = (state != IDLE);
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mc10_kbd_matrix.sv
// Directed bench for mc10_kbd_matrix with shortened SETTLE/HOLD_MIN timing.
module tb_mc10_kbd_matrix;

  localparam logic [15:0] S  = 16'd8;
  localparam logic [19:0] H  = 20'd40;
  localparam int          SI = 8;
  localparam int          HI = 40;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [7:0]  addr;
  logic [5:0]  kb_rows;
  logic        shift;
  logic        ctrl;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mc10_kbd_matrix #(.SETTLE(S), .HOLD_MIN(H)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .addr    (addr),
    .kb_rows (kb_rows),
    .shift   (shift),
    .ctrl    (ctrl),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic prs, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], prs, ext, code};
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_key = '0;
    addr    = 8'h00;
    #12;
    chk("rst_rows",  8'(kb_rows), 8'h3F);
    chk("rst_shift", 8'(shift),   8'h00);
    chk("rst_ctrl",  8'(ctrl),    8'h00);
    chk("rst_busy",  8'(busy),    8'h00);
    chk("rst_ovf",   8'(ovf),     8'h00);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    tick(3);
    chk("idle_rows", 8'(kb_rows), 8'h3F);

    // Plain press of A (row0 col1) and its address gating
    addr = 8'hFD;
    send(1'b1, 1'b0, 8'h1C);
    tick(1);
    chk("a_lat1", 8'(kb_rows), 8'h3F);
    tick(1);
    chk("a_press", 8'(kb_rows), 8'h3E);
    addr = 8'hFF; #1;
    chk("a_addr_ff", 8'(kb_rows), 8'h3F);
    addr = 8'hFD; #1;

    // Quick release is deferred until the hold time has elapsed
    send(1'b0, 1'b0, 8'h1C);
    tick(HI - 4);
    chk("a_held", 8'(kb_rows), 8'h3E);
    chk("a_busy", 8'(busy),    8'h00);
    tick(8);
    chk("a_rel", 8'(kb_rows), 8'h3F);

    // Apostrophe: synthetic SHIFT + 7
    addr = 8'h7F;
    send(1'b1, 1'b0, 8'h52);
    tick(2);
    chk("q_shift", 8'(shift),   8'h01);
    chk("q_busy",  8'(busy),    8'h01);
    chk("q_rows0", 8'(kb_rows), 8'h3F);
    tick(SI - 2);
    chk("q_settle", 8'(kb_rows), 8'h3F);
    tick(4);
    chk("q_keyon", 8'(kb_rows), 8'h2F);
    send(1'b0, 1'b0, 8'h52);
    tick(HI - 3);
    chk("q_hold",   8'(kb_rows), 8'h2F);
    chk("q_hold_s", 8'(shift),   8'h01);
    tick(4);
    chk("q_clr",    8'(kb_rows), 8'h3F);
    chk("q_rel_s",  8'(shift),   8'h01);
    chk("q_rel_b",  8'(busy),    8'h01);
    tick(SI - 2);
    chk("q_synrel_s", 8'(shift), 8'h01);
    tick(4);
    chk("q_end_s", 8'(shift), 8'h00);
    chk("q_end_b", 8'(busy),  8'h00);

    // Physical modifiers, then forced unshift of '2' while SHIFT is held
    send(1'b1, 1'b0, 8'h12);
    tick(2);
    chk("m_shift", 8'(shift), 8'h01);
    send(1'b1, 1'b1, 8'h14);
    tick(2);
    chk("m_ctrl_on", 8'(ctrl), 8'h01);
    send(1'b0, 1'b1, 8'h14);
    tick(2);
    chk("m_ctrl_off", 8'(ctrl), 8'h00);
    addr = 8'hFB;
    send(1'b1, 1'b0, 8'h1E);
    tick(2);
    chk("u_shift", 8'(shift), 8'h00);
    chk("u_busy",  8'(busy),  8'h01);
    tick(SI + 4);
    chk("u_rows",   8'(kb_rows), 8'h2F);
    chk("u_shift2", 8'(shift),   8'h00);
    send(1'b0, 1'b0, 8'h1E);
    tick(HI + SI + 10);
    chk("u_restore", 8'(shift),   8'h01);
    chk("u_idle",    8'(busy),    8'h00);
    chk("u_clr",     8'(kb_rows), 8'h3F);
    send(1'b0, 1'b0, 8'h12);
    tick(2);
    chk("m_shift_off", 8'(shift), 8'h00);

    // Events while busy: B buffered, C and D dropped
    addr = 8'hFF;
    send(1'b1, 1'b0, 8'h52);
    tick(2);
    chk("o_busy", 8'(busy), 8'h01);
    chk("o_ovf0", 8'(ovf),  8'h00);
    send(1'b1, 1'b0, 8'h32);
    tick(1);
    send(1'b1, 1'b0, 8'h21);
    tick(1);
    send(1'b1, 1'b0, 8'h23);
    tick(2);
    chk("o_ovf1", 8'(ovf), 8'h01);
    tick(SI + 2);
    send(1'b0, 1'b0, 8'h52);
    tick(HI + SI + 10);
    chk("o_idle", 8'(busy), 8'h00);
    addr = 8'hFB; #1;
    chk("o_b_set", 8'(kb_rows), 8'h3E);
    addr = 8'hF7; #1;
    chk("o_c_drop", 8'(kb_rows), 8'h3F);
    addr = 8'hEF; #1;
    chk("o_d_drop", 8'(kb_rows), 8'h3F);
    chk("o_sticky", 8'(ovf), 8'h01);

    // Asynchronous reset in the middle of SYN_SHIFT
    addr = 8'h00;
    send(1'b1, 1'b0, 8'h52);
    tick(4);
    chk("r_busy_pre",  8'(busy),  8'h01);
    chk("r_shift_pre", 8'(shift), 8'h01);
    reset_n = 1'b0;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    #2;
    chk("r_rows",  8'(kb_rows), 8'h3F);
    chk("r_shift", 8'(shift),   8'h00);
    chk("r_busy",  8'(busy),    8'h00);
    chk("r_ovf",   8'(ovf),     8'h00);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    tick(4);
    chk("r_no_spur_rows", 8'(kb_rows), 8'h3F);
    chk("r_no_spur_busy", 8'(busy),    8'h00);
    chk("r_no_spur_s",    8'(shift),   8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
